// File: rtl/npu_pkg.sv
// npu_pkg: shared Q-format widths, PWL sigmoid segment table and saturation helper.
package npu_pkg;
  localparam int NPU_ACC_W    = 48;
  localparam int NPU_ACC_FRAC = 16;
  localparam int NPU_OUT_W    = 16;
  localparam int NPU_OUT_FRAC = 8;
  // Chords of sigmoid on [i,i+1): slope Q0.16, offset Q1.16 (intercept at x=0).
  localparam logic [15:0] NPU_SIG_SLOPE [8] = '{
    16'h3B27, 16'h2655, 16'h1260, 16'h0789, 16'h02E4, 16'h0115, 16'h0066, 16'h0026};
  localparam logic [16:0] NPU_SIG_OFFSET [8] = '{
    17'h08000, 17'h094D1, 17'h0BCBC, 17'h0DD40, 17'h0EFD5, 17'h0F8E2, 17'h0FCF8, 17'h0FEBC};
  function automatic logic [15:0] npu_sat16(input logic signed [63:0] a, input int sh);
    logic signed [63:0] s;
    s = a >>> sh;
    return (s > 64'sd32767) ? 16'h7FFF : (s < -64'sd32768) ? 16'h8000 : s[15:0];
  endfunction
endpackage

// File: rtl/npu_sigmoid_pwl_rom.sv
// npu_sigmoid_pwl_rom: registered 8-entry slope/offset lookup, holds while disabled.
module npu_sigmoid_pwl_rom
  import npu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [2:0]  i_seg,
  output logic [15:0] o_slope,
  output logic [16:0] o_offset
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_slope  <= '0;
      o_offset <= '0;
    end else if (i_en) begin
      o_slope  <= NPU_SIG_SLOPE[i_seg];
      o_offset <= NPU_SIG_OFFSET[i_seg];
    end
endmodule

// File: rtl/npu_sigmoid_unit.sv
// npu_sigmoid_unit: 3-stage PWL sigmoid on a Q32.16 accumulator, Q8.8 result.
// NPU_SIGMOID_BYPASS_EN adds cfg_bypass for an identity (saturated Q8.8) path.
module npu_sigmoid_unit
  import npu_pkg::*;
#(
  parameter int ACC_W    = NPU_ACC_W,
  parameter int ACC_FRAC = NPU_ACC_FRAC,
  parameter int OUT_W    = NPU_OUT_W,
  parameter int OUT_FRAC = NPU_OUT_FRAC
) (
  input  logic             CLK,
  input  logic             npu_rst_n,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [ACC_W-1:0] acc_data,
  input  logic             acc_last,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [OUT_W-1:0] sig_data,
  output logic             sig_last
`ifdef NPU_SIGMOID_BYPASS_EN
  ,
  input  logic             cfg_bypass
`endif
);
  localparam int SH  = 16 - OUT_FRAC;
  localparam int RND = (SH == 0) ? 0 : (1 << (SH - 1));
  logic        w_adv, w_byp_in;
  logic [15:0] w_x, w_ax, w_bval, w_slope;
  logic [16:0] w_offset, w_yp, w_y;
  logic [30:0] w_prod;
  logic [19:0] w_yp_raw;
  logic [17:0] w_rnd;
  logic [OUT_W-1:0] w_sig, w_out;
  logic        r_v1, r_v2, r_last1, r_last2, r_neg1, r_neg2, r_byp1, r_byp2;
  logic [14:0] r_ax1, r_ax2;
  logic [15:0] r_bval1, r_bval2;
`ifdef NPU_SIGMOID_BYPASS_EN
  assign w_byp_in = cfg_bypass;
`else
  assign w_byp_in = 1'b0;
`endif
  assign w_adv     = ~(sig_valid & ~sig_ready);
  assign acc_ready = w_adv;
  // S1: Q4.12 window with saturation, magnitude clamped so -8.0 stays in 15 bits
  assign w_x    = npu_sat16(64'($signed(acc_data)), ACC_FRAC - 12);
  assign w_ax   = (w_x == 16'h8000) ? 16'h7FFF : (w_x[15] ? -w_x : w_x);
  assign w_bval = npu_sat16(64'($signed(acc_data)), ACC_FRAC - 8);
  npu_sigmoid_pwl_rom u_rom (
    .clk     (CLK),
    .rst_n   (npu_rst_n),
    .i_en    (w_adv),
    .i_seg   (r_ax1[14:12]),
    .o_slope (w_slope),
    .o_offset(w_offset)
  );
  // S3: evaluate the chord on |x|, mirror for negatives, round to output format
  assign w_prod   = 31'(w_slope) * 31'(r_ax2);
  assign w_yp_raw = 20'(w_offset) + 20'(w_prod >> 12);
  assign w_yp     = (w_yp_raw > 20'h10000) ? 17'h10000 : w_yp_raw[16:0];
  assign w_y      = r_neg2 ? 17'h10000 - w_yp : w_yp;
  assign w_rnd    = (18'(w_y) + 18'(RND)) >> SH;
  assign w_sig    = (w_rnd > 18'(1 << OUT_FRAC)) ? OUT_W'(1 << OUT_FRAC) : OUT_W'(w_rnd);
  assign w_out    = r_byp2 ? OUT_W'(r_bval2) : w_sig;
  always_ff @(posedge CLK or negedge npu_rst_n)
    if (!npu_rst_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      sig_valid <= 1'b0;
      sig_last  <= 1'b0;
      sig_data  <= '0;
    end else if (w_adv) begin
      r_v1      <= acc_valid;
      r_v2      <= r_v1;
      sig_valid <= r_v2;
      if (r_v2) begin
        sig_data <= w_out;
        sig_last <= r_last2;
      end
    end
  always_ff @(posedge CLK)
    if (w_adv) begin
      r_ax1   <= w_ax[14:0];
      r_neg1  <= w_x[15];
      r_last1 <= acc_last;
      r_byp1  <= w_byp_in;
      r_bval1 <= w_bval;
      r_ax2   <= r_ax1;
      r_neg2  <= r_neg1;
      r_last2 <= r_last1;
      r_byp2  <= r_byp1;
      r_bval2 <= r_bval1;
    end
endmodule
